// File: rtl/key_debounce_pkg.sv
// Shared push-button definitions: FSM state encoding, system clock rate and
// default qualification intervals (also consumed by led_8).
package key_debounce_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam int unsigned CLK_HZ              = 100_000_000;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 50;
   localparam int unsigned DEF_LONG_CYCLES     = CLK_HZ;

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// One-bit two-flop synchroniser for an asynchronous pad input.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner: synchronise, qualify press/release over a stable
// interval, and emit registered press/release/long-press pulses plus a level.
module key_debounce
   import key_debounce_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter bit          ACTIVE_HIGH     = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic key_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HW = $clog2(LONG_CYCLES + 1);

   localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [HW-1:0] hold, hold_n;
   logic          long_done, long_done_n;
   logic          press_n, release_n, long_n;
   logic          key_sync, k_s;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (key_raw),
      .q   (key_sync)
   );

   assign k_s = ACTIVE_HIGH ? key_sync : ~key_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         hold          <= '0;
         long_done     <= 1'b0;
         key_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         hold          <= hold_n;
         long_done     <= long_done_n;
         key_level     <= (state_n == PRESSED) || (state_n == RELEASE_WAIT);
         press_pulse   <= press_n;
         release_pulse <= release_n;
         long_pulse    <= long_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      hold_n      = hold;
      long_done_n = long_done;
      press_n     = 1'b0;
      release_n   = 1'b0;
      long_n      = 1'b0;
      unique case (state)
         IDLE: begin
            if (k_s) begin
               state_n = PRESS_WAIT;
               cnt_n   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!k_s) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (cnt == CNT_LAST) begin
               state_n = PRESSED;
               press_n = 1'b1;
               hold_n  = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         PRESSED: begin
            // hold advances on every PRESSED edge, including the one that leaves
            if (hold != HOLD_MAX) hold_n = hold + 1'b1;
            if (hold == HOLD_LAST && !long_done) begin
               long_n      = 1'b1;
               long_done_n = 1'b1;
            end
            if (!k_s) begin
               state_n = RELEASE_WAIT;
               cnt_n   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (k_s) begin
               state_n = PRESSED;
            end else if (cnt == CNT_LAST) begin
               state_n     = IDLE;
               release_n   = 1'b1;
               long_done_n = 1'b0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
